// File: rtl/hour_display_scan_pkg.sv
// Shared types, constants and decode helpers for the hour display scanner.
package hour_disp_pkg;

    // Scan sequencer states.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } scan_state_t;

    localparam logic [7:0] ZERO_PAT   = 8'h3F;
    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam logic [2:0] AN_OFF     = 3'b111;
    localparam logic [1:0] LAST_DIGIT = 2'd2;

    // Active-low digit enable for a digit index; out-of-range indices stay dark.
    function automatic logic [2:0] an_select(input logic [1:0] digit);
        logic [2:0] an_v;
        case (digit)
            2'd0:    an_v = 3'b110;
            2'd1:    an_v = 3'b101;
            2'd2:    an_v = 3'b011;
            default: an_v = AN_OFF;
        endcase
        return an_v;
    endfunction

    // Pick the latched pattern for a digit index; out-of-range gives no segments.
    function automatic logic [7:0] digit_pattern(input logic [2:0][7:0] shadow,
                                                 input logic [1:0]      digit);
        logic [7:0] pat_v;
        case (digit)
            2'd0:    pat_v = shadow[0];
            2'd1:    pat_v = shadow[1];
            2'd2:    pat_v = shadow[2];
            default: pat_v = 8'h00;
        endcase
        return pat_v;
    endfunction

    // Active-low segment drive, dark for a leading "0" on the hours-tens digit.
    function automatic logic [7:0] seg_drive(input logic [7:0] pat,
                                             input logic [1:0] digit,
                                             input logic       blank_lz);
        logic [7:0] seg_v;
        if (blank_lz && (digit == 2'd0) && (pat == ZERO_PAT)) begin
            seg_v = SEG_OFF;
        end else begin
            seg_v = ~pat;
        end
        return seg_v;
    endfunction

endpackage

// File: rtl/hour_display_scan_chk.sv
// Safety checker for the scanner: never more than one digit lit, and the
// display is dark whenever a frame completes.
module hour_display_scan_chk (
    input logic       clk,
    input logic       rst,
    input logic [2:0] an,
    input logic       frame_done
);

    a_one_digit: assert property (@(posedge clk) disable iff (rst)
        ($countones(~an) <= 1));

    a_dark_on_frame: assert property (@(posedge clk) disable iff (rst)
        (frame_done |-> (an == 3'b111)));

endmodule

// File: rtl/hour_display_scan_timer.sv
// Tick counter for the scan sequencer: counts enabled ticks up to a terminal
// count, then wraps to zero on the same tick that reports done.
module scan_timer
    import hour_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enb,
    input  logic [7:0] tc,
    output logic       done
);

    logic [7:0] cnt_r;

    // Terminal tick: only meaningful on an enabled, non-cleared cycle.
    always_comb begin
        done = 1'b0;
        if (enb && !clear && (cnt_r == tc)) begin
            done = 1'b1;
        end else begin
            done = 1'b0;
        end
    end

    // Tick count register: cleared on request, wraps at terminal count, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (clear) begin
            cnt_r <= 8'd0;
        end else if (enb) begin
            if (cnt_r == tc) begin
                cnt_r <= 8'd0;
            end else begin
                cnt_r <= cnt_r + 8'd1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/hour_display_scan.sv
// Three-digit multiplexed hour display scanner (hours tens, hours units,
// AM/PM). Digits are latched once per frame so a frame never mixes old and
// new values. All outputs come straight from registers; the next-output
// values are decoded from the next state so outputs line up with the state.
module hour_display_scan
    import hour_disp_pkg::*;
#(
    parameter int unsigned SHOW_TICKS = 4,
    parameter int unsigned GAP_TICKS  = 1,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic [7:0] h1,
    input  logic [7:0] h0,
    input  logic [7:0] am_pm,
    output logic [2:0] an,
    output logic [7:0] seg,
    output logic       frame_done
);

    localparam logic [7:0] SHOW_TC = 8'(SHOW_TICKS - 1);
    localparam logic [7:0] GAP_TC  = 8'(GAP_TICKS - 1);

    scan_state_t      state_r, state_s;
    logic [1:0]       digit_r, digit_s;
    logic [2:0][7:0]  shadow_r, shadow_s;
    logic [2:0]       an_r, an_s;
    logic [7:0]       seg_r, seg_s;
    logic             frame_done_r, frame_done_s;

    logic             tmr_clear_s;
    logic [7:0]       tmr_tc_s;
    logic             tmr_done_s;

    // Timer control: cleared throughout LOAD, terminal count follows the phase.
    always_comb begin
        tmr_clear_s = 1'b0;
        tmr_tc_s    = SHOW_TC;
        if (state_r == LOAD) begin
            tmr_clear_s = 1'b1;
            tmr_tc_s    = SHOW_TC;
        end else if (state_r == GAP) begin
            tmr_clear_s = 1'b0;
            tmr_tc_s    = GAP_TC;
        end else begin
            tmr_clear_s = 1'b0;
            tmr_tc_s    = SHOW_TC;
        end
    end

    scan_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clear_s),
        .enb   (enb),
        .tc    (tmr_tc_s),
        .done  (tmr_done_s)
    );

    // Next state, digit, shadows and the registered-output values they imply.
    always_comb begin
        state_s      = state_r;
        digit_s      = digit_r;
        shadow_s     = shadow_r;
        frame_done_s = 1'b0;
        an_s         = AN_OFF;
        seg_s        = SEG_OFF;

        case (state_r)
            LOAD: begin
                shadow_s = {am_pm, h0, h1};
                digit_s  = 2'd0;
                state_s  = SHOW;
            end
            SHOW: begin
                if (tmr_done_s) begin
                    state_s = GAP;
                end else begin
                    state_s = SHOW;
                end
            end
            GAP: begin
                if (tmr_done_s) begin
                    if (digit_r == LAST_DIGIT) begin
                        state_s      = LOAD;
                        frame_done_s = 1'b1;
                    end else begin
                        digit_s = digit_r + 2'd1;
                        state_s = SHOW;
                    end
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = LOAD;
                digit_s = 2'd0;
            end
        endcase

        if (state_s == SHOW) begin
            an_s  = an_select(digit_s);
            seg_s = seg_drive(digit_pattern(shadow_s, digit_s), digit_s, BLANK_LZ);
        end else begin
            an_s  = AN_OFF;
            seg_s = SEG_OFF;
        end
    end

    // State and output registers; reset darkens the display immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= LOAD;
            digit_r      <= 2'd0;
            shadow_r     <= {8'h00, 8'h00, 8'h00};
            an_r         <= AN_OFF;
            seg_r        <= SEG_OFF;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            digit_r      <= digit_s;
            shadow_r     <= shadow_s;
            an_r         <= an_s;
            seg_r        <= seg_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign frame_done = frame_done_r;

    hour_display_scan_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .an         (an_r),
        .frame_done (frame_done_r)
    );

endmodule
